sm83_alu_serial: RTL

Parametrised, multi-cycle successor to the SM83 nibble ALU. Processes a word of `ALU_WIDTH*SLICES` bits one `ALU_WIDTH`-bit slice per clock, rippling carry between slices through a register. Produces the SM83 Z/N/H/C flags. Sits beside the register file as a start/done coprocessor for 8-bit (`SLICES=2`) and 16-bit (`SLICES=4`) arithmetic.

---
 rtl/sm83_alu_pkg.sv | 37 +++
 rtl/sm83_alu_slice.sv | 45 ++++
 rtl/sm83_alu_serial.sv | 127 ++++++++++++
 3 files changed

// File: rtl/sm83_alu_pkg.sv
// Shared types for the serial SM83 ALU: op codes, flag bundle, FSM states.
package sm83_alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_ADC = 3'd1,
    OP_SUB = 3'd2,
    OP_SBC = 3'd3,
    OP_AND = 3'd4,
    OP_XOR = 3'd5,
    OP_OR  = 3'd6,
    OP_CP  = 3'd7
  } alu_op_t;

  typedef struct packed {
    logic z;
    logic n;
    logic h;
    logic c;
  } alu_flags_t;

  typedef enum logic {
    IDLE,
    RUN
  } alu_state_t;

  // Raw adder carry entering slice 0; subtraction runs as a + ~b + cin.
  function automatic logic init_carry(alu_op_t o, logic ci);
    unique case (o)
      OP_ADC:        return ci;
      OP_SUB, OP_CP: return 1'b1;
      OP_SBC:        return ~ci;
      default:       return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/sm83_alu_slice.sv
// One combinational ALU slice: bit-ripple adder whose carry chain is killed for logic ops.
module sm83_alu_slice
  import sm83_alu_pkg::*;
#(
  parameter int unsigned ALU_WIDTH = 4
) (
  input  logic [ALU_WIDTH-1:0] a,
  input  logic [ALU_WIDTH-1:0] b,
  input  logic                 cin,
  input  logic [2:0]           op,
  input  logic                 negate,
  output logic [ALU_WIDTH-1:0] r,
  output logic                 cout
);

  logic kill;
  logic bb;
  logic p;
  logic g;
  logic c;

  assign kill = (op == OP_AND) || (op == OP_XOR) || (op == OP_OR);

  always_comb begin
    r  = '0;
    bb = 1'b0;
    p  = 1'b0;
    g  = 1'b0;
    c  = cin & ~kill;
    for (int unsigned i = 0; i < ALU_WIDTH; i++) begin
      bb = b[i] ^ negate;
      p  = a[i] ^ bb;
      g  = a[i] & bb;
      unique case (alu_op_t'(op))
        OP_AND:  r[i] = g;
        OP_XOR:  r[i] = p;
        OP_OR:   r[i] = a[i] | bb;
        default: r[i] = p ^ c;
      endcase
      c = (g | (p & c)) & ~kill;
    end
    cout = c;
  end

endmodule

// File: rtl/sm83_alu_serial.sv
// Start/done serial ALU: one ALU_WIDTH slice per clock, carry rippled through a register.
module sm83_alu_serial
  import sm83_alu_pkg::*;
#(
  parameter int unsigned ALU_WIDTH = 4,
  parameter int unsigned SLICES    = 2
) (
  input  logic                          clk,
  input  logic                          nreset,
  input  logic                          start,
  input  logic [2:0]                    op,
  input  logic [ALU_WIDTH*SLICES-1:0]   a,
  input  logic [ALU_WIDTH*SLICES-1:0]   b,
  input  logic                          carry_in,
  output logic                          ready,
  output logic                          done,
  output logic [ALU_WIDTH*SLICES-1:0]   result,
  output logic                          flag_z,
  output logic                          flag_n,
  output logic                          flag_h,
  output logic                          flag_c
);

  localparam int unsigned W  = ALU_WIDTH * SLICES;
  localparam int unsigned CW = (SLICES > 2) ? $clog2(SLICES) : 1;
  typedef logic [CW-1:0] cnt_t;

  alu_state_t           state;
  cnt_t                 cnt;
  alu_op_t              op_r;
  logic [W-1:0]         opa, opb, work, res_r;
  logic                 carry, half, done_r;
  alu_flags_t           flags_r;

  logic [ALU_WIDTH-1:0] s_a, s_b, s_r;
  logic                 s_cout;
  logic [W-1:0]         next_work;
  logic                 is_sub, is_logic, last;

  assign is_sub   = (op_r == OP_SUB) || (op_r == OP_SBC) || (op_r == OP_CP);
  assign is_logic = (op_r == OP_AND) || (op_r == OP_XOR) || (op_r == OP_OR);
  assign last     = (cnt == cnt_t'(SLICES - 1));

  always_comb begin
    s_a = '0;
    s_b = '0;
    for (int unsigned k = 0; k < SLICES; k++) begin
      if (cnt == cnt_t'(k)) begin
        s_a = opa[k*ALU_WIDTH +: ALU_WIDTH];
        s_b = opb[k*ALU_WIDTH +: ALU_WIDTH];
      end
    end
  end

  sm83_alu_slice #(.ALU_WIDTH(ALU_WIDTH)) u_slice (
    .a      (s_a),
    .b      (s_b),
    .cin    (carry),
    .op     (op_r),
    .negate (is_sub),
    .r      (s_r),
    .cout   (s_cout)
  );

  // Full word as it will look after this edge, so Z can be judged on the last slice.
  always_comb begin
    next_work = work;
    for (int unsigned k = 0; k < SLICES; k++) begin
      if (cnt == cnt_t'(k)) next_work[k*ALU_WIDTH +: ALU_WIDTH] = s_r;
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state   <= IDLE;
      cnt     <= '0;
      op_r    <= OP_ADD;
      opa     <= '0;
      opb     <= '0;
      work    <= '0;
      res_r   <= '0;
      carry   <= 1'b0;
      half    <= 1'b0;
      done_r  <= 1'b0;
      flags_r <= '0;
    end else begin
      done_r <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            state <= RUN;
            opa   <= a;
            opb   <= b;
            op_r  <= alu_op_t'(op);
            cnt   <= '0;
            carry <= init_carry(alu_op_t'(op), carry_in);
          end
        end
        RUN: begin
          work  <= next_work;
          carry <= s_cout;
          cnt   <= last ? '0 : cnt + 1'b1;
          if (cnt == '0) half <= is_sub ? ~s_cout : s_cout;
          if (last) begin
            state     <= IDLE;
            done_r    <= 1'b1;
            res_r     <= (op_r == OP_CP) ? opa : next_work;
            flags_r.z <= (next_work == '0);
            flags_r.n <= is_sub;
            flags_r.h <= is_logic ? (op_r == OP_AND) : half;
            flags_r.c <= is_logic ? 1'b0 : (is_sub ? ~s_cout : s_cout);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign ready  = (state == IDLE);
  assign done   = done_r;
  assign result = res_r;
  assign flag_z = flags_r.z;
  assign flag_n = flags_r.n;
  assign flag_h = flags_r.h;
  assign flag_c = flags_r.c;

endmodule
